// File: rtl/pc_adder_arbiter.sv
// Round-robin arbiter sharing one adder between two cores' PC updates; 2-cycle request-to-response latency.
// A full, unread response buffer stalls the single issue slot for both cores; req_ready drops while stalled.
module pc_adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_cin,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_y,
  input  logic               add_cout,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [2*WIDTH-1:0] resp_y,
  output logic [1:0]         resp_cout,
  output logic               busy
);

  logic s1_valid;
  logic s1_id;
  logic rr_ptr;
  logic s1_adv;
  logic s1_load;
  logic gnt_id;

  always_comb begin
    s1_adv    = s1_valid & (~resp_valid[s1_id] | resp_ready[s1_id]);
    s1_load   = ~s1_valid | s1_adv;
    // Contention goes to the pointer's core; otherwise whichever core asks.
    gnt_id    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    req_ready = 2'b00;
    if (s1_load && (req_valid != 2'b00))
      req_ready[gnt_id] = 1'b1;
    busy = s1_valid | resp_valid[0] | resp_valid[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      rr_ptr     <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      resp_valid <= 2'b00;
      resp_y     <= '0;
      resp_cout  <= 2'b00;
    end else begin
      if (s1_load) begin
        if (req_valid != 2'b00) begin
          s1_valid <= 1'b1;
          s1_id    <= gnt_id;
          add_a    <= gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          add_b    <= gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          add_cin  <= req_cin[gnt_id];
          rr_ptr   <= ~gnt_id;
        end else begin
          s1_valid <= 1'b0;
        end
      end
      // A refill takes priority over the drain so a buffer can turn over every cycle.
      for (int k = 0; k < 2; k++) begin
        if (s1_adv && (s1_id == 1'(k))) begin
          resp_valid[k]              <= 1'b1;
          resp_y[k*WIDTH +: WIDTH]   <= add_y;
          resp_cout[k]               <= add_cout;
        end else if (resp_ready[k]) begin
          resp_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/pc_adder_arbiter.md
Name: pc_adder_arbiter

Overview:
- Shares the single 32-bit prefix adder between the two cores' PC-update requests in the dual-core processor.
- Arbitrates the two request channels round-robin and registers the operands that drive the external adder.
- Captures the adder sum and carry and returns each result to the requesting core through a one-entry response buffer with valid/ready handshake.
- Sits in the PC-update path between the cores' fetch units and the shared adder instance.

Parameters:
- WIDTH, 32, operand/result width; must match the adder width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-core request valid; bit k = core k.
- req_ready  output  2  per-core request accepted when valid&ready at a rising edge.
- req_a  input  2*WIDTH  operand A; core k in bits [k*WIDTH +: WIDTH].
- req_b  input  2*WIDTH  operand B, same packing.
- req_cin  input  2  carry-in per core.
- add_a  output  WIDTH  registered operand A to the shared adder.
- add_b  output  WIDTH  registered operand B to the shared adder.
- add_cin  output  1  registered carry-in to the shared adder.
- add_y  input  WIDTH  adder sum; combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.
- resp_valid  output  2  per-core result valid.
- resp_ready  input  2  per-core result consumed when valid&ready.
- resp_y  output  2*WIDTH  per-core sum, same packing.
- resp_cout  output  2  per-core carry-out.
- busy  output  1  high while the issue stage or either response buffer is occupied.

Behaviour:
- Reset (async on rst_n low):
  - Issue stage empty; add_a=0, add_b=0, add_cin=0.
  - resp_valid=0, resp_y=0, resp_cout=0, busy=0.
  - Round-robin pointer = core 0.
  - Reset mid-operation discards any in-flight request and any held result; no response is produced for it.
- Pipeline:
  - Stage 1 (issue register): s1_valid, s1_id, operands; drives add_a/add_b/add_cin.
  - Stage 2: per-core response buffer.
  - Latency: request accepted at edge N -> resp_valid[k] high after edge N+1 (2 cycles), provided no stall.
- Issue advance:
  - s1_adv = s1_valid & (~resp_valid[s1_id] | resp_ready[s1_id]).
  - On s1_adv: resp_y[s1_id] <= add_y, resp_cout[s1_id] <= add_cout, resp_valid[s1_id] <= 1.
  - Drain and refill of the same buffer in one edge is allowed (throughput 1/cycle per core).
  - A response buffer not being refilled clears resp_valid[k] on valid&ready.
- Issue acceptance:
  - Stage 1 can load when ~s1_valid | s1_adv.
  - When it can load, at most one grant per cycle.
  - Only one core valid -> that core is granted.
  - Both valid -> the pointer's core is granted.
  - req_ready[k]=1 only for the granted core; req_ready is combinational from req_valid, pointer and stage state, and both bits are 0 when stage 1 cannot load.
  - No request -> s1_valid <= 0 on advance; add_* hold their last value.
- Round-robin:
  - After any grant to core k, the pointer moves to core 1-k.
  - The pointer is unchanged when there is no grant.
  - Under continuous dual requests, grants alternate 0,1,0,1.
- Stall:
  - If stage 1 is blocked (target buffer full, not being read), add_* and s1_* hold.
  - No new grant while stage 1 is blocked.
  - A blocked result for core k also blocks core 1-k (single shared issue slot); this is intended.
- Arithmetic:
  - The sum is the adder's; the block does not modify add_y/add_cout.
  - Wrap-around (e.g. 0xFFFFFFFF+1) returns y=0, cout=1 unchanged.
- busy = s1_valid | resp_valid[0] | resp_valid[1].

Test Plan:
- Reset then single request, core0 A=0x0000_1000, B=4, cin=0, resp_ready=1 -> req_ready[0]=1 at edge 0; resp_valid[0]=1 after edge 1 with resp_y[0]=0x0000_1004, cout=0; resp_valid[1] stays 0.
- Both cores request every cycle (core0 A=0x100 B=4, core1 A=0x200 B=8), resp_ready=2'b11, 8 cycles -> grants alternate starting core0; 4 results each, 0x104 and 0x208, one result per cycle after fill.
- Wrap: core1 A=0xFFFF_FFFF, B=0, cin=1 -> resp_y[1]=0, resp_cout[1]=1.
- Back-pressure: resp_ready[0]=0, core0 issues 3 requests -> first lands in buffer, second held in stage 1, req_ready=0 for both cores; core1 request waits; releasing resp_ready[0] drains in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 while s1_valid=1 and resp_valid[1]=1 -> all outputs 0 immediately, pointer=core0; after release, the first dual request grants core0.
- Idle: no requests for 5 cycles -> busy=0, add_* stable, pointer unchanged.
